uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 fixed-baud transmitter. It adds a runtime baud divisor, selectable parity, 1 or 2 stop bits, and a valid/ready input handshake backed by a one-entry holding register, so consecutive frames go out with no idle gap. It sits between the system-side byte source (debug/loader unit) and the serial TX pin.

---
 rtl/uart_tx_cfg.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//   UART transmitter with a runtime baud divisor, selectable parity and one or
//   two stop bits. Bytes enter through a valid/ready handshake into a one-entry
//   holding register, so the shifter can start the next frame on the same edge
//   that finishes the previous stop bit (no idle gap between frames).
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_div          clock cycles per serial bit (0 and 1 behave as 2)
//   i_parity_mode  00 none, 01 even, 10 odd, 11 none
//   i_two_stop     1 = two stop bits, 0 = one stop bit
//   i_valid        i_data holds a byte to send
//   i_data         byte to transmit (DBIT bits, sent LSB first)
//   o_ready        holding register empty; byte taken when i_valid && o_ready
//   o_tx           serial line, idle high
//   o_busy         a frame is being shifted out (START..STOP)
//   o_frame_done   one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int DBIT      = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    input  logic                 i_valid,
    input  logic [DBIT-1:0]      i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam int IDX_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Control registers (reset)
    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_m1;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_two_stop;
    logic                 r_ready;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;

    // Data registers (no reset needed; qualified by control state)
    logic [DBIT-1:0]      r_shift;
    logic [DBIT-1:0]      r_hold;

    // Next-state values
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_div_m1_nxt;
    logic [IDX_W-1:0]     w_bit_idx_nxt;
    logic                 w_stop_idx_nxt;
    logic                 w_par_en_nxt;
    logic                 w_par_bit_nxt;
    logic                 w_two_stop_nxt;
    logic                 w_ready_nxt;
    logic                 w_tx_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic [DBIT-1:0]      w_shift_nxt;
    logic [DBIT-1:0]      w_hold_nxt;

    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [DIV_WIDTH-1:0] w_div_m1;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_free;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_par_en_in;
    logic                 w_par_in;

    // Divisor below 2 would leave no room for the down-counter to reload.
    assign w_div_eff   = (i_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_div;
    assign w_div_m1    = w_div_eff - DIV_WIDTH'(1);

    assign w_tick      = (r_cnt == '0);
    assign w_last_stop = (r_state == S_STOP) && w_tick && (r_stop_idx == r_two_stop);
    // Shifter can take a new byte while idle or on the very last stop cycle.
    assign w_free      = (r_state == S_IDLE) || w_last_stop;
    // Holding register is full exactly when o_ready is low.
    assign w_load      = w_free && !r_ready;
    assign w_accept    = i_valid && r_ready;

    assign w_par_en_in = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
    assign w_par_in    = (^r_hold) ^ (i_parity_mode == 2'b10);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_m1_nxt   = r_div_m1;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_two_stop_nxt = r_two_stop;
        w_ready_nxt    = r_ready;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_shift_nxt    = r_shift;
        w_hold_nxt     = r_hold;

        if (!w_tick) begin
            w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt   = S_DATA;
                    w_cnt_nxt     = r_div_m1;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt = r_div_m1;
                    if (r_bit_idx == IDX_W'(DBIT - 1)) begin
                        if (r_par_en) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt    = S_STOP;
                            w_tx_nxt       = 1'b1;
                            w_stop_idx_nxt = 1'b0;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt    = S_STOP;
                    w_cnt_nxt      = r_div_m1;
                    w_tx_nxt       = 1'b1;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == r_two_stop) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                        w_cnt_nxt      = r_div_m1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // A load overrides the end-of-frame transition so back-to-back frames
        // go straight from the last stop cycle into the next start bit.
        if (w_load) begin
            w_state_nxt    = S_START;
            w_cnt_nxt      = w_div_m1;
            w_div_m1_nxt   = w_div_m1;
            w_par_en_nxt   = w_par_en_in;
            w_par_bit_nxt  = w_par_in;
            w_two_stop_nxt = i_two_stop;
            w_shift_nxt    = r_hold;
            w_tx_nxt       = 1'b0;
            w_busy_nxt     = 1'b1;
            w_ready_nxt    = 1'b1;
        end

        // Accept and load are mutually exclusive: accept needs an empty
        // holding register, load needs a full one.
        if (w_accept) begin
            w_ready_nxt = 1'b0;
            w_hold_nxt  = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div_m1   <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_ready    <= 1'b1;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div_m1   <= w_div_m1_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_two_stop <= w_two_stop_nxt;
            r_ready    <= w_ready_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        r_shift <= w_shift_nxt;
        r_hold  <= w_hold_nxt;
    end

    assign o_ready      = r_ready;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Directed and randomized frames for uart_tx_cfg. Expected line waveforms
//   come from a frame model that lists the frame's bits (start, data LSB
//   first, optional parity, stop bits) and expands each bit to div cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int DBIT      = 8;
    localparam int DIV_WIDTH = 16;

    typedef bit bitq_t[$];

    logic                 clk;
    logic                 i_reset;
    logic [DIV_WIDTH-1:0] i_div;
    logic [1:0]           i_parity_mode;
    logic                 i_two_stop;
    logic                 i_valid;
    logic [DBIT-1:0]      i_data;
    logic                 o_ready;
    logic                 o_tx;
    logic                 o_busy;
    logic                 o_frame_done;

    int n_cmp = 0;
    int n_mis = 0;

    uart_tx_cfg #(
        .DBIT      (DBIT),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_div         (i_div),
        .i_parity_mode (i_parity_mode),
        .i_two_stop    (i_two_stop),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_tx          (o_tx),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference frame: list of line levels, one entry per serial bit.
    function automatic bitq_t frame_bits(input logic [DBIT-1:0] d, input int mode,
                                         input bit two_stop);
        bitq_t q;
        int    ones;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (mode == 1) q.push_back(bit'(ones % 2));
        if (mode == 2) q.push_back(bit'(1 - (ones % 2)));
        q.push_back(1'b1);
        if (two_stop) q.push_back(1'b1);
        return q;
    endfunction

    // Checks every cycle of one frame, starting at the negedge after the load.
    task automatic check_frame(input logic [DBIT-1:0] d, input int div, input int mode,
                               input bit two_stop, input bit first_done,
                               input int rdy_lo_from, input int rel_at);
        bitq_t q;
        int    ed;
        int    cyc;
        q   = frame_bits(d, mode, two_stop);
        ed  = (div < 2) ? 2 : div;
        cyc = 0;
        foreach (q[b]) begin
            for (int c = 0; c < ed; c++) begin
                @(negedge clk);
                chk("tx", o_tx, q[b]);
                chk("busy", o_busy, 1'b1);
                chk("done", o_frame_done, (cyc == 0) ? first_done : 1'b0);
                chk("ready", o_ready, (rdy_lo_from >= 0 && cyc >= rdy_lo_from) ? 1'b0 : 1'b1);
                if (cyc == rel_at) i_valid = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic end_check();
        @(negedge clk);
        chk("end_done", o_frame_done, 1'b1);
        chk("end_busy", o_busy, 1'b0);
        chk("end_tx", o_tx, 1'b1);
        chk("end_ready", o_ready, 1'b1);
        @(negedge clk);
        chk("end_done_clr", o_frame_done, 1'b0);
        chk("end_tx_idle", o_tx, 1'b1);
    endtask

    // Presents a byte, waits (bounded) for the accept edge, then checks the
    // single idle cycle that precedes the start bit.
    task automatic accept_byte(input logic [DBIT-1:0] d);
        int w;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        w = 0;
        while (!o_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("ready_wait", o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        chk("acc_ready_low", o_ready, 1'b0);
        chk("acc_tx_idle", o_tx, 1'b1);
        chk("acc_busy_low", o_busy, 1'b0);
    endtask

    task automatic one_frame(input logic [DBIT-1:0] d, input int div, input int mode,
                             input bit two_stop);
        i_div         = DIV_WIDTH'(div);
        i_parity_mode = 2'(mode);
        i_two_stop    = two_stop;
        accept_byte(d);
        check_frame(d, div, mode, two_stop, 1'b0, -1, -1);
        end_check();
    endtask

    initial begin
        logic [DBIT-1:0] rd;
        int              rdiv;
        int              rmode;
        bit              rts;

        i_reset       = 1'b1;
        i_div         = DIV_WIDTH'(4);
        i_parity_mode = 2'b00;
        i_two_stop    = 1'b0;
        i_valid       = 1'b0;
        i_data        = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", o_tx, 1'b1);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_frame_done, 1'b0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", o_tx, 1'b1);
        chk("post_rst_ready", o_ready, 1'b1);

        // Basic frame, parity variants, divisor clamp with two stop bits
        one_frame(8'hA5, 4, 0, 1'b0);
        one_frame(8'h07, 4, 1, 1'b0);
        one_frame(8'h07, 4, 2, 1'b0);
        one_frame(8'h07, 4, 3, 1'b0);
        one_frame(8'h00, 0, 1, 1'b1);
        one_frame(8'hFF, 1, 2, 1'b1);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            rd    = DBIT'($urandom);
            rdiv  = int'($urandom_range(0, 6));
            rmode = int'($urandom_range(0, 3));
            rts   = bit'($urandom_range(0, 1));
            one_frame(rd, rdiv, rmode, rts);
        end

        // Back-to-back with backpressure
        i_div         = DIV_WIDTH'(4);
        i_parity_mode = 2'b00;
        i_two_stop    = 1'b0;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_ready_full", o_ready, 1'b0);
        i_data = 8'h3C;
        check_frame(8'h55, 4, 0, 1'b0, 1'b0, 1, -1);
        check_frame(8'h3C, 4, 0, 1'b0, 1'b1, -1, 0);
        end_check();

        // Config change mid-frame
        i_div         = DIV_WIDTH'(4);
        i_parity_mode = 2'b00;
        i_two_stop    = 1'b0;
        accept_byte(8'h5A);
        fork
            check_frame(8'h5A, 4, 0, 1'b0, 1'b0, -1, -1);
            begin
                repeat (10) @(negedge clk);
                i_div         = DIV_WIDTH'(8);
                i_parity_mode = 2'b01;
            end
        join
        end_check();
        accept_byte(8'h5A);
        check_frame(8'h5A, 8, 1, 1'b0, 1'b0, -1, -1);
        end_check();

        // Reset mid-frame with a byte held
        i_div         = DIV_WIDTH'(4);
        i_parity_mode = 2'b00;
        i_two_stop    = 1'b0;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        i_data = 8'h99;
        for (int c = 0; c < 18; c++) @(negedge clk);
        chk("pre_rst_tx_bit3", o_tx, 1'b0);
        chk("pre_rst_ready_held", o_ready, 1'b0);
        chk("pre_rst_busy", o_busy, 1'b1);
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("async_rst_tx", o_tx, 1'b1);
        chk("async_rst_ready", o_ready, 1'b1);
        chk("async_rst_busy", o_busy, 1'b0);
        chk("async_rst_done", o_frame_done, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("post_abort_tx", o_tx, 1'b1);
            chk("post_abort_busy", o_busy, 1'b0);
            chk("post_abort_done", o_frame_done, 1'b0);
        end

        // Recovery after abort
        one_frame(8'h81, 3, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
